// File: rtl/iiitb_4bbc_pkg.sv
// Shared types and constants for the 4-bit up/down counter sequencer.
//   CNT_W / STEPS_W : default counter width and step-field width
//   MAX_CNT         : terminal count of the default-width counter
//   op_e            : command opcodes carried on cmd_op
//   state_e         : sequencer FSM states
package iiitb_4bbc_pkg;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned STEPS_W = 4;
    localparam int unsigned MAX_CNT = (1 << CNT_W) - 1;

    typedef enum logic [2:0] {
        OP_NOP       = 3'd0,
        OP_LOAD      = 3'd1,
        OP_UP_N      = 3'd2,
        OP_DOWN_N    = 3'd3,
        OP_BOUNCE_N  = 3'd4,
        OP_FREE_UP   = 3'd5,
        OP_FREE_DOWN = 3'd6,
        OP_ILLEGAL   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_LOAD = 2'd2
    } state_e;

endpackage

// File: rtl/iiitb_4bbc_shadow.sv
// Shadow copy of the external up/down/load counter.
// Consumes exactly the strobes driven to the real counter, so both advance on
// the same edge and cannot drift apart.
//   clk_i, rst_ni    : clock, async active-low reset
//   en_i, up_i       : step enable and direction
//   load_i           : load strobe (load_val_i)
//   count_o          : registered count
//   wrap_o           : registered pulse on a MAX->0 or 0->MAX step
//   next_count_c_o   : combinational value count_o takes at the next edge
module iiitb_4bbc_shadow
    import iiitb_4bbc_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             up_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic             wrap_o,
    output logic [WIDTH-1:0] next_count_c_o
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;

    // Next count and wrap detect; load and enable are never driven together.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i) begin
            if (up_i) begin
                count_d = count_q + WIDTH'(1);
                wrap_d  = (count_q == '1);
            end else begin
                count_d = count_q - WIDTH'(1);
                wrap_d  = (count_q == '0);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count_o        = count_q;
    assign wrap_o         = wrap_q;
    assign next_count_c_o = count_d;

endmodule

// File: rtl/iiitb_4bbc_seq.sv
// Command-driven sequencer for a 4-bit up/down counter.
// Accepts one command at a time (valid/ready), drives the counter's enable,
// direction and load strobes, and reports done/aborted/wrap/err.
//   Clk, reset                  : clock, async active-low reset
//   cmd_valid/cmd_ready         : command handshake (ready only when idle)
//   cmd_op/cmd_steps/cmd_load_val : opcode, step count (0 = 2**STEP_W), load value
//   abort                       : terminate the running command
//   cnt_en/cnt_up/cnt_load/cnt_load_val : counter strobes
//   count_o                     : shadow count
//   busy/done/aborted/wrap/err  : status
module iiitb_4bbc_seq
    import iiitb_4bbc_pkg::*;
#(
    parameter int unsigned WIDTH  = CNT_W,
    parameter int unsigned STEP_W = STEPS_W
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic [WIDTH-1:0]  cmd_load_val,
    input  logic              abort,
    output logic              cnt_en,
    output logic              cnt_up,
    output logic              cnt_load,
    output logic [WIDTH-1:0]  cnt_load_val,
    output logic [WIDTH-1:0]  count_o,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              wrap,
    output logic              err
);

    // One extra bit so a full 2**STEP_W step count is representable.
    localparam int unsigned REM_W = STEP_W + 1;

    state_e            state_q, state_d;
    op_e               op_q, op_d, op_in;
    logic [REM_W-1:0]  rem_q, rem_d, rem_init;
    logic              dir_q, dir_d;
    logic              accept;
    logic              free_run;
    logic [WIDTH-1:0]  next_count;

    logic              cmd_ready_d, busy_d;
    logic              cnt_en_d, cnt_up_d, cnt_load_d;
    logic [WIDTH-1:0]  cnt_load_val_d;
    logic              done_d, aborted_d, err_d;

    assign op_in    = op_e'(cmd_op);
    assign accept   = cmd_valid && cmd_ready;
    assign free_run = (op_q == OP_FREE_UP) || (op_q == OP_FREE_DOWN);
    assign rem_init = (cmd_steps == '0) ? REM_W'(1 << STEP_W) : REM_W'(cmd_steps);

    // Next state and next registered outputs.
    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        rem_d          = rem_q;
        dir_d          = dir_q;
        cnt_en_d       = 1'b0;
        cnt_up_d       = 1'b0;
        cnt_load_d     = 1'b0;
        cnt_load_val_d = cnt_load_val;
        done_d         = 1'b0;
        aborted_d      = 1'b0;
        err_d          = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d  = op_in;
                    rem_d = rem_init;
                    dir_d = 1'b1;
                    case (op_in)
                        OP_NOP: begin
                            done_d = 1'b1;
                        end
                        OP_LOAD: begin
                            state_d        = S_LOAD;
                            cnt_load_d     = 1'b1;
                            cnt_load_val_d = cmd_load_val;
                        end
                        OP_UP_N, OP_FREE_UP: begin
                            state_d  = S_RUN;
                            cnt_en_d = 1'b1;
                            cnt_up_d = 1'b1;
                        end
                        OP_DOWN_N, OP_FREE_DOWN: begin
                            state_d  = S_RUN;
                            cnt_en_d = 1'b1;
                        end
                        OP_BOUNCE_N: begin
                            // First step starts upward unless already at MAX.
                            state_d  = S_RUN;
                            cnt_en_d = 1'b1;
                            dir_d    = (next_count != '1);
                            cnt_up_d = dir_d;
                        end
                        default: begin
                            err_d  = 1'b1;
                            done_d = 1'b1;
                        end
                    endcase
                end
            end

            S_LOAD: begin
                // The load strobe is already out; abort only qualifies done.
                state_d   = S_IDLE;
                done_d    = 1'b1;
                aborted_d = abort;
            end

            S_RUN: begin
                if (abort) begin
                    state_d   = S_IDLE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else if (!free_run && (rem_q == REM_W'(1))) begin
                    state_d = S_IDLE;
                    rem_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_en_d = 1'b1;
                    if (!free_run) begin
                        rem_d = rem_q - REM_W'(1);
                    end
                    case (op_q)
                        OP_UP_N, OP_FREE_UP: cnt_up_d = 1'b1;
                        OP_BOUNCE_N: begin
                            // Reverse before stepping past either end.
                            if (dir_q && (next_count == '1)) begin
                                dir_d = 1'b0;
                            end else if (!dir_q && (next_count == '0)) begin
                                dir_d = 1'b1;
                            end
                            cnt_up_d = dir_d;
                        end
                        default: cnt_up_d = 1'b0;
                    endcase
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            op_q         <= OP_NOP;
            rem_q        <= '0;
            dir_q        <= 1'b0;
            cmd_ready    <= 1'b0;
            busy         <= 1'b0;
            cnt_en       <= 1'b0;
            cnt_up       <= 1'b0;
            cnt_load     <= 1'b0;
            cnt_load_val <= '0;
            done         <= 1'b0;
            aborted      <= 1'b0;
            err          <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            rem_q        <= rem_d;
            dir_q        <= dir_d;
            cmd_ready    <= cmd_ready_d;
            busy         <= busy_d;
            cnt_en       <= cnt_en_d;
            cnt_up       <= cnt_up_d;
            cnt_load     <= cnt_load_d;
            cnt_load_val <= cnt_load_val_d;
            done         <= done_d;
            aborted      <= aborted_d;
            err          <= err_d;
        end
    end

    // Shadow counter driven by the same strobes as the external counter.
    iiitb_4bbc_shadow #(
        .WIDTH (WIDTH)
    ) u_shadow (
        .clk_i          (Clk),
        .rst_ni         (reset),
        .en_i           (cnt_en),
        .up_i           (cnt_up),
        .load_i         (cnt_load),
        .load_val_i     (cnt_load_val),
        .count_o        (count_o),
        .wrap_o         (wrap),
        .next_count_c_o (next_count)
    );

endmodule

// File: tb/tb_iiitb_4bbc_seq.sv
// Bench for iiitb_4bbc_seq: directed scenarios plus random commands, checked
// every cycle against a command-script model of the sequencer.
module tb_iiitb_4bbc_seq;

    localparam int unsigned W  = 4;
    localparam int unsigned SW = 4;
    localparam int MAXV = 15;
    localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, UPN = 3'd2, DNN = 3'd3,
                           BNC = 3'd4, FUP = 3'd5, FDN = 3'd6, ILL = 3'd7;

    logic          Clk, reset, cmd_valid, cmd_ready, abort;
    logic [2:0]    cmd_op;
    logic [SW-1:0] cmd_steps;
    logic [W-1:0]  cmd_load_val, cnt_load_val, count_o;
    logic          cnt_en, cnt_up, cnt_load, busy, done, aborted, wrap, err;

    int checks = 0;
    int errors = 0;
    int n_en = 0, n_wrap = 0, n_flip = 0;
    logic prev_en = 1'b0, prev_up = 1'b0;

    // One expected cycle of outputs.
    typedef struct packed {
        logic         en;
        logic         up;
        logic         load;
        logic [W-1:0] lv;
        logic         done;
        logic         aborted;
        logic         err;
    } ent_t;

    ent_t q[$];
    ent_t cur, nxt;
    bit   m_free = 0, m_free_up = 0, exp_ready = 0, exp_wrap = 0;
    int   m_count = 0;

    iiitb_4bbc_seq dut (
        .Clk          (Clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_steps    (cmd_steps),
        .cmd_load_val (cmd_load_val),
        .abort        (abort),
        .cnt_en       (cnt_en),
        .cnt_up       (cnt_up),
        .cnt_load     (cnt_load),
        .cnt_load_val (cnt_load_val),
        .count_o      (count_o),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted),
        .wrap         (wrap),
        .err          (err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Expand an accepted command into the cycles it must produce.
    task automatic build(input logic [2:0] op, input logic [SW-1:0] st, input logic [W-1:0] lv);
        ent_t e;
        int   n, c;
        bit   d;
        n = (st == 0) ? (1 << SW) : int'(st);
        case (op)
            NOP: begin
                e = '0; e.done = 1'b1; q.push_back(e);
            end
            LOAD: begin
                e = '0; e.load = 1'b1; e.lv = lv; q.push_back(e);
                e = '0; e.done = 1'b1; q.push_back(e);
            end
            UPN, DNN: begin
                for (int i = 0; i < n; i++) begin
                    e = '0; e.en = 1'b1; e.up = (op == UPN); q.push_back(e);
                end
                e = '0; e.done = 1'b1; q.push_back(e);
            end
            BNC: begin
                c = m_count;
                d = 1'b1;
                for (int i = 0; i < n; i++) begin
                    if (d && c == MAXV) d = 1'b0;
                    else if (!d && c == 0) d = 1'b1;
                    e = '0; e.en = 1'b1; e.up = d; q.push_back(e);
                    c = d ? (c + 1) % 16 : (c + 15) % 16;
                end
                e = '0; e.done = 1'b1; q.push_back(e);
            end
            FUP, FDN: begin
                m_free    = 1'b1;
                m_free_up = (op == FUP);
            end
            default: begin
                e = '0; e.done = 1'b1; e.err = 1'b1; q.push_back(e);
            end
        endcase
    endtask

    // Model step on each rising edge, then compare all outputs.
    always @(posedge Clk) begin
        if (!reset) begin
            q.delete();
            m_free    = 1'b0;
            cur       = '0;
            exp_ready = 1'b0;
            exp_wrap  = 1'b0;
            m_count   = 0;
        end else begin
            if (cur.load) begin
                m_count  = int'(cur.lv);
                exp_wrap = 1'b0;
            end else if (cur.en) begin
                exp_wrap = cur.up ? (m_count == MAXV) : (m_count == 0);
                m_count  = cur.up ? (m_count + 1) % 16 : (m_count + 15) % 16;
            end else begin
                exp_wrap = 1'b0;
            end
            nxt = '0;
            if ((cur.en || cur.load) && abort) begin
                q.delete();
                m_free      = 1'b0;
                nxt.done    = 1'b1;
                nxt.aborted = 1'b1;
            end else begin
                if (exp_ready && cmd_valid) build(cmd_op, cmd_steps, cmd_load_val);
                if (q.size() > 0) nxt = q.pop_front();
                else if (m_free) begin
                    nxt.en = 1'b1;
                    nxt.up = m_free_up;
                end
            end
            cur       = nxt;
            exp_ready = !(nxt.en || nxt.load);
        end
        #1;
        chk("cmd_ready", int'(cmd_ready), int'(exp_ready));
        chk("busy",      int'(busy),      int'(cur.en || cur.load));
        chk("cnt_en",    int'(cnt_en),    int'(cur.en));
        if (cur.en) chk("cnt_up", int'(cnt_up), int'(cur.up));
        chk("cnt_load",  int'(cnt_load),  int'(cur.load));
        if (cur.load) chk("cnt_load_val", int'(cnt_load_val), int'(cur.lv));
        chk("count_o",   int'(count_o),   m_count);
        chk("done",      int'(done),      int'(cur.done));
        chk("aborted",   int'(aborted),   int'(cur.aborted));
        chk("err",       int'(err),       int'(cur.err));
        chk("wrap",      int'(wrap),      int'(exp_wrap));
        if (cnt_en) n_en++;
        if (wrap) n_wrap++;
        if (cnt_en && prev_en && (cnt_up != prev_up)) n_flip++;
        prev_en = cnt_en;
        prev_up = cnt_up;
    end

    task automatic send(input logic [2:0] op, input int st, input int lv);
        int t;
        t = 0;
        while (cmd_ready !== 1'b1 && t < 200) begin
            @(negedge Clk);
            t++;
        end
        if (t >= 200) chk("ready_timeout", 0, 1);
        cmd_valid    = 1'b1;
        cmd_op       = op;
        cmd_steps    = SW'(st);
        cmd_load_val = W'(lv);
        @(negedge Clk);
        cmd_valid = 1'b0;
    endtask

    // Cycles from presenting the command until done is seen.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < 200) begin
            @(negedge Clk);
            cyc++;
        end
        if (cyc >= 200) chk("done_timeout", 0, 1);
    endtask

    int lat, b_en, b_wr, b_fl, t;

    initial begin
        reset = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_steps = '0;
        cmd_load_val = '0; abort = 1'b0;
        repeat (3) @(negedge Clk);
        chk("rst_ready", int'(cmd_ready), 0);
        chk("rst_count", int'(count_o), 0);
        reset = 1'b1;
        @(negedge Clk);
        chk("ready_after_rst", int'(cmd_ready), 1);

        // UP_N 3 from 0
        b_en = n_en; b_wr = n_wrap;
        send(UPN, 3, 0);
        wait_done(lat);
        chk("t1_lat", lat, 4);
        chk("t1_en", n_en - b_en, 3);
        chk("t1_count", int'(count_o), 3);
        chk("t1_wrap", n_wrap - b_wr, 0);
        chk("t1_ready", int'(cmd_ready), 1);

        // LOAD 14, UP_N 4 across the top
        send(LOAD, 0, 14);
        wait_done(lat);
        chk("t2_load", int'(count_o), 14);
        b_wr = n_wrap;
        send(UPN, 4, 0);
        wait_done(lat);
        chk("t2_count", int'(count_o), 2);
        chk("t2_wrap", n_wrap - b_wr, 1);

        // LOAD 1, DOWN_N 16
        send(LOAD, 0, 1);
        wait_done(lat);
        b_en = n_en; b_wr = n_wrap;
        send(DNN, 0, 0);
        wait_done(lat);
        chk("t3_en", n_en - b_en, 16);
        chk("t3_count", int'(count_o), 1);
        chk("t3_wrap", n_wrap - b_wr, 1);

        // LOAD 13, BOUNCE_N 6
        send(LOAD, 0, 13);
        wait_done(lat);
        b_en = n_en; b_wr = n_wrap; b_fl = n_flip;
        send(BNC, 6, 0);
        wait_done(lat);
        chk("t4_en", n_en - b_en, 6);
        chk("t4_count", int'(count_o), 11);
        chk("t4_flip", n_flip - b_fl, 1);
        chk("t4_wrap", n_wrap - b_wr, 0);

        // FREE_UP from 0, abort on the 5th enable
        send(LOAD, 0, 0);
        wait_done(lat);
        b_en = n_en;
        send(FUP, 0, 0);
        t = 0;
        while ((n_en - b_en) < 5 && t < 100) begin
            @(negedge Clk);
            t++;
        end
        if (t >= 100) chk("t5_timeout", 0, 1);
        abort = 1'b1;
        @(negedge Clk);
        abort = 1'b0;
        chk("t5_done", int'(done), 1);
        chk("t5_aborted", int'(aborted), 1);
        chk("t5_count", int'(count_o), 5);
        chk("t5_ready", int'(cmd_ready), 1);
        chk("t5_en", int'(cnt_en), 0);

        // Illegal op, then reset in the middle of UP_N 8
        send(ILL, 0, 0);
        chk("t6_err", int'(err), 1);
        chk("t6_done", int'(done), 1);
        chk("t6_strobe", int'(cnt_en | cnt_load), 0);
        @(negedge Clk);
        chk("t6_err_pulse", int'(err), 0);
        send(UPN, 8, 0);
        repeat (2) @(negedge Clk);
        chk("t6_midrun", int'(cnt_en), 1);
        #2 reset = 1'b0;
        #1;
        chk("t6_rst_en", int'(cnt_en), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_count", int'(count_o), 0);
        chk("t6_rst_ready", int'(cmd_ready), 0);
        chk("t6_rst_done", int'(done), 0);
        @(negedge Clk);
        @(negedge Clk);
        reset = 1'b1;
        @(negedge Clk);
        chk("t6_no_done", int'(done), 0);

        // Random traffic with occasional abort and reset
        for (int cyc = 0; cyc < 3000; cyc++) begin
            cmd_valid    = ($urandom_range(0, 3) != 0);
            cmd_op       = 3'($urandom_range(0, 7));
            cmd_steps    = SW'($urandom_range(0, 15));
            cmd_load_val = W'($urandom);
            abort        = ($urandom_range(0, 19) == 0);
            reset        = ($urandom_range(0, 499) != 0);
            @(negedge Clk);
        end
        cmd_valid = 1'b0;
        abort     = 1'b0;
        reset     = 1'b1;
        repeat (5) @(negedge Clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
